// File: rtl/c1_frame_scheduler.sv
// rtl/c1_frame_scheduler.sv - frame controller and 2-way round-robin arbiter for the C1 layer
module c1_frame_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int IMG_PIX = 1024,
  parameter int OUT_PIX = 784,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               frame_done,
  output logic               frame_err,
  output logic               mem_rd_en,
  output logic [10:0]        mem_rd_addr,
  input  logic [7:0]         mem_rd_data,
  output logic               c1_start,
  input  logic               c1_weights_loaded,
  output logic               c1_pixel_valid,
  output logic [7:0]         c1_pixel,
  output logic               c1_conv_ready,
  input  logic               c1_out_valid,
  input  logic               c1_done,
  input  logic               sink_ready
);

  localparam int PW = $clog2(IMG_PIX);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(IMG_PIX - 1);
  localparam logic [9:0]    OUT_FULL = 10'(OUT_PIX);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_W, S_STREAM, S_DRAIN, S_FINISH, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic          owner;
  logic          ptr;
  logic [PW-1:0] pix_cnt;
  logic [9:0]    out_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          overflow;
  logic          done_seen;
  logic          done_q;
  logic          pix_valid_q;
  logic          winner;
  logic          accept;
  logic          done_rise;
  logic          in_frame;

  // Winner is the pointer's requester if it asks, otherwise the other one.
  assign winner    = req[ptr] ? ptr : ~ptr;
  assign accept    = c1_out_valid && c1_conv_ready;
  assign done_rise = c1_done && !done_q;
  assign in_frame  = (state == S_WAIT_W) || (state == S_STREAM) || (state == S_DRAIN);

  // Outputs decode from registered state so reset forces every one to 0 at once.
  assign grant          = (state != S_IDLE) ? (NUM_REQ'(1) << owner) : '0;
  assign c1_start       = (state == S_START);
  assign mem_rd_en      = (state == S_STREAM);
  assign mem_rd_addr    = mem_rd_en ? {owner, pix_cnt} : '0;
  assign c1_pixel_valid = pix_valid_q;
  assign c1_pixel       = pix_valid_q ? mem_rd_data : '0;
  assign c1_conv_ready  = sink_ready && ((state == S_STREAM) || (state == S_DRAIN));
  assign frame_done     = (state == S_FINISH) && !overflow;
  assign frame_err      = (state == S_ERROR) || ((state == S_FINISH) && overflow);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: DRAIN completion wins over its timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req != '0) state_nxt = S_START;
      S_START:  state_nxt = S_WAIT_W;
      S_WAIT_W: begin
        if (c1_weights_loaded)       state_nxt = S_STREAM;
        else if (tmo_cnt == TMO_LAST) state_nxt = S_ERROR;
      end
      S_STREAM: if (pix_cnt == PIX_LAST) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (out_cnt == OUT_FULL && done_seen)                    state_nxt = S_FINISH;
        else if (!accept && !done_rise && tmo_cnt == TMO_LAST) state_nxt = S_ERROR;
      end
      S_FINISH: state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Owner/pointer, pixel and result counters, timeout and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= 1'b0;
      ptr         <= 1'b0;
      pix_cnt     <= '0;
      out_cnt     <= '0;
      tmo_cnt     <= '0;
      overflow    <= 1'b0;
      done_seen   <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= mem_rd_en;
      done_q      <= c1_done;
      case (state)
        S_IDLE:   if (req != '0) owner <= winner;
        S_START: begin
          pix_cnt   <= '0;
          out_cnt   <= '0;
          tmo_cnt   <= '0;
          overflow  <= 1'b0;
          done_seen <= c1_done;
        end
        S_WAIT_W: tmo_cnt <= c1_weights_loaded ? '0 : tmo_cnt + TW'(1);
        S_STREAM: begin
          pix_cnt <= pix_cnt + PW'(1);
          tmo_cnt <= '0;
        end
        S_DRAIN:  tmo_cnt <= (accept || done_rise) ? '0 : tmo_cnt + TW'(1);
        S_FINISH: ptr <= ~owner;
        S_ERROR:  ptr <= ~owner;
        default:  ;
      endcase
      if (in_frame) begin
        if (c1_done) done_seen <= 1'b1;
        if (accept) begin
          if (out_cnt == OUT_FULL) overflow <= 1'b1;
          else                     out_cnt  <= out_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_c1_frame_scheduler.sv
// tb/tb_c1_frame_scheduler.sv - scoreboard bench for c1_frame_scheduler
module tb_c1_frame_scheduler;

  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        frame_done, frame_err;
  logic        mem_rd_en;
  logic [10:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        c1_start;
  logic        c1_weights_loaded;
  logic        c1_pixel_valid;
  logic [7:0]  c1_pixel;
  logic        c1_conv_ready;
  logic        c1_out_valid;
  logic        c1_done;
  logic        sink_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:2047];
  logic [10:0] addr_q  [$];
  logic [7:0]  pix_q   [$];
  logic [1:0]  grant_q [$];

  int accepts    = 0;
  int res_target = 0;
  bit res_go     = 1'b0;
  bit done_sent  = 1'b0;
  bit sink_toggle = 1'b0;
  bit data_phase = 1'b0;

  int rf_start_wait, rf_rd_lat, rf_pv, rf_run, rf_dones, rf_errs, rf_acc;
  bit rf_to;
  logic [1:0] rf_grant_after;

  c1_frame_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .frame_done(frame_done), .frame_err(frame_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .c1_start(c1_start), .c1_weights_loaded(c1_weights_loaded),
    .c1_pixel_valid(c1_pixel_valid), .c1_pixel(c1_pixel),
    .c1_conv_ready(c1_conv_ready), .c1_out_valid(c1_out_valid),
    .c1_done(c1_done), .sink_ready(sink_ready)
  );

  always #5 clk = ~clk;

  // Image memory: data one cycle after the read strobe.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'h5A;

  // Count accepted results.
  always @(posedge clk) if (c1_out_valid && c1_conv_ready) accepts <= accepts + 1;

  // Downstream ready: either held high or toggling every cycle.
  always @(posedge clk) begin
    #2;
    sink_ready = sink_toggle ? ~sink_ready : 1'b1;
  end

  // C1 result model: offers results until the target, then one c1_done pulse.
  always @(negedge clk) begin
    if (!res_go) begin
      c1_out_valid = 1'b0;
      c1_done      = 1'b0;
      done_sent    = 1'b0;
    end else begin
      c1_out_valid = (accepts < res_target);
      c1_done      = !done_sent && (accepts >= res_target);
      if (c1_done) done_sent = 1'b1;
    end
  end

  // Scoreboard side: pop grant/address/pixel expectations as the DUT produces them.
  always @(negedge clk) begin
    logic [1:0]  eg;
    logic [10:0] ea;
    logic [7:0]  ep;
    if (reset) data_phase = 1'b0;
    else begin
      if (c1_start) begin
        n_checks++;
        if (grant_q.size() == 0) begin
          n_fail++; $display("FAIL start_unexpected: got grant %b, required no start", grant);
        end else begin
          eg = grant_q.pop_front();
          if (grant !== eg) begin n_fail++; $display("FAIL grant: got %b required %b", grant, eg); end
        end
      end
      if (mem_rd_en) begin
        n_checks++;
        if (addr_q.size() == 0) begin
          n_fail++; $display("FAIL addr_unexpected: got %h, required no read", mem_rd_addr);
        end else begin
          ea = addr_q.pop_front();
          if (mem_rd_addr !== ea) begin n_fail++; $display("FAIL mem_rd_addr: got %h required %h", mem_rd_addr, ea); end
        end
      end
      if (c1_pixel_valid) begin
        n_checks++;
        if (pix_q.size() == 0) begin
          n_fail++; $display("FAIL pixel_unexpected: got %h, required no pixel", c1_pixel);
        end else begin
          ep = pix_q.pop_front();
          if (c1_pixel !== ep) begin n_fail++; $display("FAIL c1_pixel: got %h required %h", c1_pixel, ep); end
        end
      end
      if (mem_rd_en) data_phase = 1'b1;
      if (frame_done || frame_err) data_phase = 1'b0;
      n_checks++;
      if (c1_conv_ready !== (data_phase && sink_ready)) begin
        n_fail++; $display("FAIL conv_ready: got %b required %b", c1_conv_ready, data_phase && sink_ready);
      end
    end
  end

  task automatic push_frame(input logic own);
    logic [10:0] a;
    grant_q.push_back(own ? 2'b10 : 2'b01);
    for (int i = 0; i < 1024; i++) begin
      a = {own, 10'(i)};
      addr_q.push_back(a);
      pix_q.push_back(mem[a]);
    end
  endtask

  task automatic flush_queues();
    addr_q.delete();
    pix_q.delete();
    grant_q.delete();
  endtask

  // Drives one frame from grant to completion and records what was observed.
  task automatic run_frame(input int wdelay, input int nres, input bit drop_req);
    int acc0;
    int run;
    bit fin;
    rf_start_wait = 0; rf_rd_lat = 0; rf_pv = 0; rf_run = 0;
    rf_dones = 0; rf_errs = 0; rf_acc = 0; rf_to = 1'b0; run = 0; fin = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (c1_start) begin rf_start_wait = k; break; end
    end
    if (rf_start_wait == 0) begin rf_to = 1'b1; return; end
    if (drop_req) req = 2'b00;
    repeat (wdelay) @(negedge clk);
    c1_weights_loaded = 1'b1;
    acc0 = accepts;
    res_target = accepts + nres;
    res_go = 1'b1;
    for (int k = 1; k <= 8000; k++) begin
      @(negedge clk);
      if (mem_rd_en && rf_rd_lat == 0) rf_rd_lat = k;
      if (c1_pixel_valid) begin
        rf_pv++; run++;
        if (run > rf_run) rf_run = run;
      end else run = 0;
      if (frame_done) rf_dones++;
      if (frame_err)  rf_errs++;
      if (frame_done || frame_err) begin fin = 1'b1; break; end
    end
    if (!fin) rf_to = 1'b1;
    c1_weights_loaded = 1'b0;
    res_go = 1'b0;
    rf_acc = accepts - acc0;
    @(negedge clk);
    if (frame_done) rf_dones++;
    if (frame_err)  rf_errs++;
    rf_grant_after = grant;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; c1_weights_loaded = 1'b1; sink_ready = 1'b1;
    c1_out_valid = 1'b0; c1_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grant, frame_done, frame_err, mem_rd_en, c1_start} !== 6'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {grant, frame_done, frame_err, mem_rd_en, c1_start});
    end
    n_checks++;
    if (mem_rd_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %h required 000", mem_rd_addr); end
    n_checks++;
    if ({c1_pixel_valid, c1_pixel, c1_conv_ready} !== 10'd0) begin
      n_fail++; $display("FAIL reset_pixel: got %b required 0", {c1_pixel_valid, c1_pixel, c1_conv_ready});
    end
    req = 2'b00; c1_weights_loaded = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    push_frame(1'b0); push_frame(1'b1); push_frame(1'b0);
    req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      run_frame(3, 784, f == 2);
      n_checks++;
      if (rf_to || rf_dones != 1 || rf_errs != 0) begin
        n_fail++; $display("FAIL rr_outcome[%0d]: got to=%0d done=%0d err=%0d required 0/1/0", f, rf_to, rf_dones, rf_errs);
      end
      n_checks++;
      if (rf_start_wait != 1) begin n_fail++; $display("FAIL rr_start_latency[%0d]: got %0d required 1", f, rf_start_wait); end
      n_checks++;
      if (rf_pv != 1024 || rf_run != 1024) begin
        n_fail++; $display("FAIL rr_pixels[%0d]: got %0d/%0d required 1024/1024", f, rf_pv, rf_run);
      end
      n_checks++;
      if (rf_grant_after !== 2'b00) begin n_fail++; $display("FAIL rr_grant_release[%0d]: got %b required 00", f, rf_grant_after); end
    end
    n_checks++;
    if (addr_q.size() != 0 || grant_q.size() != 0) begin
      n_fail++; $display("FAIL rr_leftover: got %0d addrs %0d grants required 0", addr_q.size(), grant_q.size());
    end
  endtask

  task automatic test_single_frame();
    push_frame(1'b0);
    req = 2'b01;
    run_frame(100, 784, 1'b1);
    n_checks++;
    if (rf_to || rf_dones != 1 || rf_errs != 0) begin
      n_fail++; $display("FAIL single_outcome: got to=%0d done=%0d err=%0d required 0/1/0", rf_to, rf_dones, rf_errs);
    end
    n_checks++;
    if (rf_rd_lat != 1) begin n_fail++; $display("FAIL single_rd_latency: got %0d required 1", rf_rd_lat); end
    n_checks++;
    if (rf_pv != 1024 || rf_run != 1024) begin
      n_fail++; $display("FAIL single_pixels: got %0d/%0d required 1024/1024", rf_pv, rf_run);
    end
    n_checks++;
    if (rf_acc != 784) begin n_fail++; $display("FAIL single_accepts: got %0d required 784", rf_acc); end
    n_checks++;
    if (rf_grant_after !== 2'b00) begin n_fail++; $display("FAIL single_grant_release: got %b required 00", rf_grant_after); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (addr_q.size() != 0 || pix_q.size() != 0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL single_leftover: got %0d addrs %0d pixels grant %b required 0/0/00", addr_q.size(), pix_q.size(), grant);
    end
  endtask

  task automatic test_weight_timeout();
    int k_err;
    int rd;
    int dn;
    k_err = 0; rd = 0; dn = 0;
    grant_q.push_back(2'b01);
    req = 2'b01;
    for (int k = 1; k <= 20 && !c1_start; k++) @(negedge clk);
    n_checks++;
    if (!c1_start) begin n_fail++; $display("FAIL tmo_start: got no c1_start required one"); end
    req = 2'b00;
    for (int k = 1; k <= TIMEOUT + 100; k++) begin
      @(negedge clk);
      if (mem_rd_en) rd++;
      if (frame_done) dn++;
      if (frame_err) begin k_err = k; break; end
    end
    n_checks++;
    if (k_err < TIMEOUT || k_err > TIMEOUT + 2) begin
      n_fail++; $display("FAIL tmo_latency: got %0d required %0d +-1", k_err, TIMEOUT + 1);
    end
    n_checks++;
    if (rd != 0 || dn != 0) begin n_fail++; $display("FAIL tmo_activity: got rd=%0d done=%0d required 0/0", rd, dn); end
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b00 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_release: got grant %b err %b required 00/0", grant, frame_err);
    end
  endtask

  task automatic test_backpressure();
    push_frame(1'b1);
    req = 2'b10;
    sink_toggle = 1'b1;
    run_frame(2, 784, 1'b1);
    sink_toggle = 1'b0;
    n_checks++;
    if (rf_to || rf_dones != 1 || rf_errs != 0) begin
      n_fail++; $display("FAIL bp_outcome: got to=%0d done=%0d err=%0d required 0/1/0", rf_to, rf_dones, rf_errs);
    end
    n_checks++;
    if (rf_acc != 784) begin n_fail++; $display("FAIL bp_accepts: got %0d required 784", rf_acc); end
  endtask

  task automatic test_excess_outputs();
    push_frame(1'b0);
    req = 2'b01;
    run_frame(2, 785, 1'b1);
    n_checks++;
    if (rf_to || rf_dones != 0 || rf_errs != 1) begin
      n_fail++; $display("FAIL excess_outcome: got to=%0d done=%0d err=%0d required 0/0/1", rf_to, rf_dones, rf_errs);
    end
    n_checks++;
    if (rf_acc != 785 || rf_pv != 1024) begin
      n_fail++; $display("FAIL excess_counts: got acc=%0d pv=%0d required 785/1024", rf_acc, rf_pv);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit found;
    found = 1'b0;
    push_frame(1'b0);
    req = 2'b01;
    for (int k = 1; k <= 20 && !c1_start; k++) @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    c1_weights_loaded = 1'b1;
    res_target = accepts + 784;
    res_go = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (mem_rd_en && mem_rd_addr[9:0] == 10'd500) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mid_reach_500: got no read of pixel 500 required one"); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, frame_done, frame_err, mem_rd_en, mem_rd_addr, c1_start, c1_pixel_valid, c1_pixel, c1_conv_ready} !== 27'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h required 0",
        {grant, frame_done, frame_err, mem_rd_en, mem_rd_addr, c1_start, c1_pixel_valid, c1_pixel, c1_conv_ready});
    end
    flush_queues();
    res_go = 1'b0;
    c1_weights_loaded = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_frame(1'b1);
    req = 2'b10;
    run_frame(2, 784, 1'b1);
    n_checks++;
    if (rf_to || rf_dones != 1 || rf_errs != 0) begin
      n_fail++; $display("FAIL mid_restart_outcome: got to=%0d done=%0d err=%0d required 0/1/0", rf_to, rf_dones, rf_errs);
    end
    push_frame(1'b0);
    req = 2'b11;
    run_frame(2, 784, 1'b1);
    n_checks++;
    if (rf_to || rf_dones != 1) begin
      n_fail++; $display("FAIL mid_ptr_follow: got to=%0d done=%0d required 0/1", rf_to, rf_dones);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'((i * 37) ^ (i >> 3));
    test_reset();
    test_round_robin();
    test_single_frame();
    test_weight_timeout();
    test_backpressure();
    test_excess_outputs();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/c1_frame_scheduler.md
# c1_frame_scheduler

Frame-level controller and two-requester arbiter for the C1 convolution layer (`c1_layer_top`). It grants the layer to one requester at a time using round-robin. For each granted frame it pulses start, waits for weight loading, and streams 1024 pixels from a shared image memory. It then counts the 784 per-channel-group results and reports completion or error. It sits between the frame-request sources and the C1 layer plus its image buffer.

## Interface
- `NUM_REQ`, 2, number of requesters (fixed at 2; round-robin over 2).
- `IMG_PIX`, 1024, pixels per frame (32x32).
- `OUT_PIX`, 784, expected results per frame (28x28).
- `TIMEOUT`, 4096, max cycles without progress in WAIT_W or DRAIN.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state cleared.
- `req` in 2: level frame requests, one bit per requester.
- `grant` out 2: one-hot owner of the current frame, or 0.
- `frame_done` out 1: one-cycle pulse, frame completed correctly.
- `frame_err` out 1: one-cycle pulse, frame aborted (timeout or excess outputs).
- `mem_rd_en` out 1: image memory read strobe.
- `mem_rd_addr` out 11: {owner index, pixel index[9:0]}.
- `mem_rd_data` in 8: read data, valid exactly 1 cycle after `mem_rd_en`.
- `c1_start` out 1: one-cycle start pulse to the C1 layer.
- `c1_weights_loaded` in 1: level, weights ready.
- `c1_pixel_valid` out 1: pixel strobe to the C1 layer.
- `c1_pixel` out 8: pixel data (signed, passed through unchanged).
- `c1_conv_ready` out 1: ready toward the C1 result port.
- `c1_out_valid` in 1: C1 result valid.
- `c1_done` in 1: C1 frame done.
- `sink_ready` in 1: downstream result-consumer ready.

## Operation
- States: IDLE, START, WAIT_W, STREAM, DRAIN, FINISH, ERROR.
- **IDLE**
  - Arbitration when `req` != 0: the priority pointer `ptr` names the requester checked first.
  - Winner = `ptr` if `req[ptr]`, else the other bit.
  - Latch the owner, set `grant`, go to START.
- **START**: `c1_start`=1 for this one cycle. Clear counters and the sticky `done_seen` flag. Go to WAIT_W.
- **WAIT_W**
  - `c1_weights_loaded`=1 → go to STREAM.
  - Otherwise the timeout counter increments; reaching `TIMEOUT` → go to ERROR.
- **STREAM**
  - `mem_rd_en`=1 every cycle; `mem_rd_addr` = {owner, pix_cnt}, where pix_cnt runs 0..1023, +1 per cycle.
  - After the cycle with pix_cnt=1023 → go to DRAIN.
  - The pixel stream never stalls.
- **Pixel path**: `c1_pixel_valid` is `mem_rd_en` delayed 1 cycle; `c1_pixel` = `mem_rd_data`.
- **Result accept**: `c1_conv_ready` = `sink_ready` in STREAM and DRAIN, else 0.
  - A result is accepted when `c1_out_valid` && `c1_conv_ready`; `out_cnt` (10 bits) increments.
  - An accept when `out_cnt`=`OUT_PIX` sets the sticky `overflow` flag; the count saturates.
- **`done_seen`**: set by `c1_done`=1 in any state from START through DRAIN.
- **DRAIN**
  - When `out_cnt`=`OUT_PIX` and `done_seen` → go to FINISH.
  - The timeout counter resets on each accept or on `c1_done` rising. Otherwise it increments; reaching `TIMEOUT` → go to ERROR.
- **FINISH**
  - `frame_done`=1 if `overflow`=0; otherwise `frame_err`=1 instead.
  - Clear `grant`; `ptr` ← owner^1. Go to IDLE.
- **ERROR**: `frame_err`=1; clear `grant`; `ptr` ← owner^1; go to IDLE.
- **Mid-frame request changes**: dropping `req` is ignored and the frame runs to completion. New requests wait until IDLE.

## Timing
- **Reset values**: state=IDLE, `ptr`=0, all counters 0, flags 0. Every output is 0: `grant`, `frame_done`, `frame_err`, `mem_rd_en`, `mem_rd_addr`, `c1_start`, `c1_pixel_valid`, `c1_pixel`, `c1_conv_ready`.
- **Start path**: `req` seen in IDLE at cycle N → `grant` and `c1_start` at N+1; WAIT_W from N+2.
- **Stream path**: `c1_weights_loaded` sampled high at cycle M →
  - `mem_rd_en` addr 0 at M+1, addr 1023 at M+1024;
  - `c1_pixel_valid` from M+2 to M+1025 inclusive (1024 cycles);
  - DRAIN from M+1025.
- **Finish path**: DRAIN exit condition true at cycle F → FINISH at F+1 (pulse) → IDLE at F+2. A new grant is possible at F+3 at the earliest.
- **Simultaneous `c1_done` and last accept**: both are registered, and FINISH follows one cycle later.
- **Reset mid-frame**: all activity stops immediately, with no pulse on `frame_done` or `frame_err`.

## Test plan
- **Single frame**: `req`=01, weights load after 100 cycles, model returns 784 results then `c1_done`.
  - `grant`=01; `c1_start` 1 cycle.
  - 1024 consecutive `c1_pixel_valid` with addresses 0..1023 matching the memory.
  - `frame_done` exactly once; `grant` returns to 0.
- **Round-robin**: `req`=11 held.
  - Grants alternate 01, 10, 01.
  - Memory addresses take bit 10 = 0 / 1 / 0 respectively.
- **Weight timeout**: `c1_weights_loaded` never rises → `frame_err` at START+1+`TIMEOUT` (±1 cycle); no `mem_rd_en` ever.
- **Backpressure**: `sink_ready` toggles 50%.
  - `c1_conv_ready` mirrors `sink_ready` in STREAM and DRAIN.
  - Exactly 784 accepts counted, then `frame_done`.
- **Excess outputs**: model sends 785 results → `frame_err` pulse, no `frame_done`.
- **Reset mid-stream**: assert `reset` at pixel 500.
  - All outputs 0 the same cycle; `ptr`=0.
  - The next `req`=10 gets grant 10 and restarts at address {1,0}.
